// File: rtl/key_event_decoder_if.sv
// key_event_decoder_if
//   Bundles the key input and the decoded gesture outputs of key_event_decoder.
//   slave  : decoder side  (receives nKey, drives Pressed and the strobes)
//   master : consumer side (drives nKey, observes Pressed and the strobes)
// Signals:
//   nKey        debounced key level, 0 = pressed (may be asynchronous)
//   Pressed     registered level, 1 while the synchronized key is pressed
//   ShortPulse  one-cycle strobe for a single short click
//   DoublePulse one-cycle strobe for a double click
//   LongPulse   one-cycle strobe when the long-press threshold is reached
//   RepeatPulse one-cycle strobe every repeat period while a long press is held
interface key_event_decoder_if;
  logic nKey;
  logic Pressed;
  logic ShortPulse;
  logic DoublePulse;
  logic LongPulse;
  logic RepeatPulse;

  modport slave (
    input  nKey,
    output Pressed, ShortPulse, DoublePulse, LongPulse, RepeatPulse
  );

  modport master (
    output nKey,
    input  Pressed, ShortPulse, DoublePulse, LongPulse, RepeatPulse
  );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Classifies gestures on a debounced active-low key into one-cycle strobes:
//   short click, double click, long press, and auto-repeat while a long press
//   is held.
// Ports:
//   Clk     system clock, rising edge
//   Rst     asynchronous, active-high reset
//   keyBus  key_event_decoder_if.slave (nKey in; Pressed and strobes out)
// Parameters:
//   TICK_DIV  clock cycles per 1 ms tick
//   LONG_MS   hold time qualifying a long press (ms)
//   DOUBLE_MS maximum release gap between the clicks of a double click (ms)
//   REPEAT_MS auto-repeat period while a long press is held (ms)
module key_event_decoder #(
  parameter int TICK_DIV  = 50000,
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 250,
  parameter int REPEAT_MS = 200
) (
  input  logic                  Clk,
  input  logic                  Rst,
  key_event_decoder_if.slave    keyBus
);

  localparam int MsMaxA = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
  localparam int MsMax  = (MsMaxA > REPEAT_MS) ? MsMaxA : REPEAT_MS;
  localparam int PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MsW    = $clog2(MsMax + 1);

  localparam logic [PreW-1:0] PreLast    = PreW'(TICK_DIV - 1);
  localparam logic [MsW-1:0]  LongLast   = MsW'(LONG_MS - 1);
  localparam logic [MsW-1:0]  DoubleLast = MsW'(DOUBLE_MS - 1);
  localparam logic [MsW-1:0]  RepeatLast = MsW'(REPEAT_MS - 1);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} stateT;

  stateT           stateReg, stateNext;
  logic            syncReg, keyReg;      // keyReg is the synchronized level K
  logic [PreW-1:0] preReg;
  logic [MsW-1:0]  msReg;
  logic            tick, timedState, restart, clearCnt;
  logic            pressedReg, shortReg, doubleReg, longReg, repeatReg;
  logic            shortNext, doubleNext, longNext, repeatNext;

  // The interval expires on the last cycle of its final millisecond, so the
  // transition edge lands exactly N*TICK_DIV cycles after state entry.
  assign tick = (preReg == PreLast);

  // Counters only run in states that time something; IDLE and PRESS2 hold
  // them at zero so nothing can wrap during an arbitrarily long stay.
  assign timedState = (stateReg == PRESS1) || (stateReg == WAIT2) || (stateReg == LONG);
  assign clearCnt   = restart || (stateNext != stateReg) || !timedState;

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  // Next-state logic. The key level is tested first in every state so that a
  // key change coinciding with a timeout wins over the timeout.
  always_comb begin
    stateNext = stateReg;
    restart   = 1'b0;
    case (stateReg)
      IDLE:   if (!keyReg) stateNext = PRESS1;
      PRESS1: begin
        if (keyReg)                       stateNext = WAIT2;
        else if (tick && msReg == LongLast) stateNext = LONG;
      end
      WAIT2: begin
        if (!keyReg)                        stateNext = PRESS2;
        else if (tick && msReg == DoubleLast) stateNext = IDLE;
      end
      PRESS2: if (keyReg) stateNext = IDLE;
      LONG: begin
        if (keyReg)                           stateNext = IDLE;
        else if (tick && msReg == RepeatLast) restart   = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output logic: next values of the strobes, registered below so each one
  // rises on the same edge as the transition it belongs to.
  always_comb begin
    shortNext  = (stateReg == WAIT2)  &&  keyReg && tick && (msReg == DoubleLast);
    doubleNext = (stateReg == PRESS2) &&  keyReg;
    longNext   = (stateReg == PRESS1) && !keyReg && tick && (msReg == LongLast);
    repeatNext = (stateReg == LONG)   && restart;
  end

  // Synchronizer, timebase and registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      syncReg    <= 1'b1;
      keyReg     <= 1'b1;
      preReg     <= '0;
      msReg      <= '0;
      pressedReg <= 1'b0;
      shortReg   <= 1'b0;
      doubleReg  <= 1'b0;
      longReg    <= 1'b0;
      repeatReg  <= 1'b0;
    end else begin
      syncReg <= keyBus.nKey;
      keyReg  <= syncReg;
      if (clearCnt) begin
        preReg <= '0;
        msReg  <= '0;
      end else if (tick) begin
        preReg <= '0;
        msReg  <= msReg + MsW'(1);
      end else begin
        preReg <= preReg + PreW'(1);
      end
      pressedReg <= ~keyReg;
      shortReg   <= shortNext;
      doubleReg  <= doubleNext;
      longReg    <= longNext;
      repeatReg  <= repeatNext;
    end
  end

  assign keyBus.Pressed     = pressedReg;
  assign keyBus.ShortPulse  = shortReg;
  assign keyBus.DoublePulse = doubleReg;
  assign keyBus.LongPulse   = longReg;
  assign keyBus.RepeatPulse = repeatReg;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder
//   Directed gestures on nKey; each gesture pushes its expected strobe kind and
//   cycle into a scoreboard queue, and a monitor pops and compares whenever a
//   strobe appears. Timing: TICK_DIV=4, LONG_MS=8, DOUBLE_MS=5, REPEAT_MS=3.
module tb_key_event_decoder;
  localparam int TD = 4, LM = 8, DM = 5, RM = 3;
  localparam int EV_SHORT = 0, EV_DOUBLE = 1, EV_LONG = 2, EV_REPEAT = 3;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  typedef struct { int kind; int when; } expT;
  expT   sbq[$];
  string evName[4] = '{"short", "double", "long", "repeat"};

  key_event_decoder_if bus();

  key_event_decoder #(
    .TICK_DIV(TD), .LONG_MS(LM), .DOUBLE_MS(DM), .REPEAT_MS(RM)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .keyBus(bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endfunction

  function automatic void pushExp(int kind, int when);
    expT e;
    e.kind = kind;
    e.when = when;
    sbq.push_back(e);
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic checkAllZero(string tag);
    check({tag, "_Pressed"},     int'(bus.Pressed),     0);
    check({tag, "_ShortPulse"},  int'(bus.ShortPulse),  0);
    check({tag, "_DoublePulse"}, int'(bus.DoublePulse), 0);
    check({tag, "_LongPulse"},   int'(bus.LongPulse),   0);
    check({tag, "_RepeatPulse"}, int'(bus.RepeatPulse), 0);
  endtask

  // Monitor: one transaction per strobe seen on the falling edge.
  always @(negedge Clk) begin : monitor
    int  n;
    int  kind;
    expT e;
    n = int'(bus.ShortPulse) + int'(bus.DoublePulse) + int'(bus.LongPulse) + int'(bus.RepeatPulse);
    if (!Rst && n != 0) begin
      kind = bus.ShortPulse ? EV_SHORT : bus.DoublePulse ? EV_DOUBLE :
             bus.LongPulse  ? EV_LONG  : EV_REPEAT;
      $display("event %s at cycle %0d", evName[kind], cyc);
      check("single_strobe", n, 1);
      if (sbq.size() == 0) begin
        check({"unexpected_", evName[kind]}, cyc, -1);
      end else begin
        e = sbq.pop_front();
        check({"kind_", evName[e.kind]}, kind, e.kind);
        check({"cycle_", evName[e.kind]}, cyc, e.when);
      end
    end
  end

  initial begin : stimulus
    int c0;
    bus.nKey = 1'b1;
    Rst      = 1'b1;

    // Reset state, then a quiet period with no strobe allowed.
    step(3);
    checkAllZero("reset");
    Rst = 1'b0;
    step(100);

    // Short click: PRESS1 at +3, WAIT2 at +13, ShortPulse 20 later.
    c0 = cyc;
    pushExp(EV_SHORT, c0 + 33);
    bus.nKey = 1'b0; step(10);
    bus.nKey = 1'b1; step(60);

    // Double click: second release at +28, DoublePulse 3 cycles later.
    c0 = cyc;
    pushExp(EV_DOUBLE, c0 + 31);
    bus.nKey = 1'b0; step(10);
    bus.nKey = 1'b1; step(8);
    bus.nKey = 1'b0; step(10);
    bus.nKey = 1'b1; step(40);

    // Long press with two repeats; release at +60 precedes the third.
    c0 = cyc;
    pushExp(EV_LONG,   c0 + 35);
    pushExp(EV_REPEAT, c0 + 47);
    pushExp(EV_REPEAT, c0 + 59);
    bus.nKey = 1'b0; step(10);
    check("pressed_held", int'(bus.Pressed), 1);
    step(50);
    bus.nKey = 1'b1; step(5);
    check("pressed_released", int'(bus.Pressed), 0);
    step(40);

    // Boundary: K returns to 1 in the threshold cycle, so WAIT2 at +35.
    c0 = cyc;
    pushExp(EV_SHORT, c0 + 55);
    bus.nKey = 1'b0; step(32);
    bus.nKey = 1'b1; step(60);

    // Mid-gesture reset while in LONG with the key held.
    c0 = cyc;
    pushExp(EV_LONG, c0 + 35);
    bus.nKey = 1'b0; step(40);
    Rst = 1'b1;
    #1;
    checkAllZero("midreset");
    step(2);
    Rst = 1'b0;
    c0 = cyc;
    pushExp(EV_LONG, c0 + 35);
    step(40);
    bus.nKey = 1'b1; step(40);

    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
